// File: rtl/mips_cpu_run_pkg.sv
// Shared types and constants for the MIPS CPU run controller: FSM state
// encoding, run status codes and a saturating counter helper.
package mips_cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_WAIT,
    ST_RUN,
    ST_DONE
  } run_state_t;

  localparam logic [1:0] STATUS_NONE         = 2'b00;
  localparam logic [1:0] STATUS_HALTED       = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT      = 2'b10;
  localparam logic [1:0] STATUS_NEVER_ACTIVE = 2'b11;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mips_cpu_run_stall_gen.sv
// Periodic CPU clock-enable gap generator: drops the enable for one cycle in
// every STALL_PERIOD while enabled. STALL_PERIOD of 0 or 1 means no stalls.
module mips_cpu_run_stall_gen #(
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic clk_enable
);

  localparam bit                STALL_ON = (STALL_PERIOD >= 2);
  localparam int unsigned       CW       = STALL_ON ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0]     LAST     = CW'(STALL_ON ? STALL_PERIOD - 1 : 0);

  logic [CW-1:0] count;

  // enable is the controller's next-state RUN decode, so clk_enable is a
  // lookahead for the coming cycle; the controller registers it.
  always_ff @(posedge clk) begin
    if (reset || !enable || !STALL_ON) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign clk_enable = !(STALL_ON && (count == LAST));

endmodule

// File: rtl/mips_cpu_run_controller.sv
// Run controller for a MIPS CPU under test: resets it, waits for it to go
// active, runs it with optional stalls and reports halt, timeout or no-start.
module mips_cpu_run_controller
  import mips_cpu_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned ACTIVE_WAIT    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned STALL_PERIOD   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cpu_active,
  input  logic [31:0] cpu_register_v0,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] cycle_count,
  output logic [31:0] result_v0
);

  localparam logic [31:0] RST_LAST  = (RESET_CYCLES > 1) ? 32'(RESET_CYCLES - 1) : '0;
  localparam logic [31:0] WAIT_LAST = (ACTIVE_WAIT > 1) ? 32'(ACTIVE_WAIT - 1) : '0;

  run_state_t  state, state_next;
  logic [31:0] phase_cnt, phase_cnt_next;
  logic [1:0]  status_next;
  logic [31:0] cycle_count_next, result_v0_next, count_inc;
  logic        cpu_reset_next, cpu_clk_enable_next, busy_next, done_next;
  logic        stall_clk_en;

  mips_cpu_run_stall_gen #(
    .STALL_PERIOD(STALL_PERIOD)
  ) u_stall_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (state_next == ST_RUN),
    .clk_enable(stall_clk_en)
  );

  always_comb begin
    state_next       = state;
    phase_cnt_next   = phase_cnt;
    status_next      = status;
    cycle_count_next = cycle_count;
    result_v0_next   = result_v0;
    count_inc        = cpu_clk_enable ? sat_inc(cycle_count) : cycle_count;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next       = ST_RST;
          phase_cnt_next   = '0;
          status_next      = STATUS_NONE;
          cycle_count_next = '0;
          result_v0_next   = '0;
        end
      end
      ST_RST: begin
        if (phase_cnt == RST_LAST) begin
          state_next     = ST_WAIT;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 32'd1;
        end
      end
      ST_WAIT: begin
        if (cpu_active) begin
          state_next = ST_RUN;
        end else if (phase_cnt == WAIT_LAST) begin
          state_next  = ST_DONE;
          status_next = STATUS_NEVER_ACTIVE;
        end else begin
          phase_cnt_next = phase_cnt + 32'd1;
        end
      end
      ST_RUN: begin
        cycle_count_next = count_inc;
        // Halt is tested first so a halt on the final allowed cycle wins.
        if (!cpu_active) begin
          state_next     = ST_DONE;
          status_next    = STATUS_HALTED;
          result_v0_next = cpu_register_v0;
        end else if (count_inc >= TIMEOUT_CYCLES) begin
          state_next     = ST_DONE;
          status_next    = STATUS_TIMEOUT;
          result_v0_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and then registered.
    cpu_reset_next      = (state_next == ST_RST);
    busy_next           = (state_next == ST_RST) || (state_next == ST_WAIT) ||
                          (state_next == ST_RUN);
    done_next           = (state_next == ST_DONE);
    cpu_clk_enable_next = (state_next == ST_RST) || (state_next == ST_WAIT) ||
                          ((state_next == ST_RUN) && stall_clk_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      phase_cnt      <= '0;
      status         <= STATUS_NONE;
      cycle_count    <= '0;
      result_v0      <= '0;
      cpu_reset      <= 1'b0;
      cpu_clk_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_next;
      phase_cnt      <= phase_cnt_next;
      status         <= status_next;
      cycle_count    <= cycle_count_next;
      result_v0      <= result_v0_next;
      cpu_reset      <= cpu_reset_next;
      cpu_clk_enable <= cpu_clk_enable_next;
      busy           <= busy_next;
      done           <= done_next;
    end
  end

endmodule

// File: tb/tb_mips_cpu_run_controller.sv
// Directed bench for mips_cpu_run_controller: four parameterisations driven by
// a small behavioural CPU model, checked against hand-computed values.
module tb_mips_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start           [4];
  logic        cpu_active      [4];
  logic [31:0] cpu_register_v0 [4];
  logic        cpu_reset       [4];
  logic        cpu_clk_enable  [4];
  logic        busy            [4];
  logic        done            [4];
  logic [1:0]  status          [4];
  logic [31:0] cycle_count     [4];
  logic [31:0] result_v0       [4];

  int n_checks = 0;
  int n_fail   = 0;

  // CPU model configuration (written by the stimulus process only)
  int          act_delay    [4];
  int          halt_after   [4];
  bit          never_active [4];
  logic [31:0] halt_v0      [4];

  // CPU model observations (written by the model process only)
  int phase [4], since [4], en_count [4], run_cycles [4], stalls [4];
  int bad_en [4], rst_w [4], rst_rises [4], done_lat [4];
  bit prev_rst [4], done_seen [4];

  mips_cpu_run_controller u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .cpu_active(cpu_active[0]),
    .cpu_register_v0(cpu_register_v0[0]), .cpu_reset(cpu_reset[0]),
    .cpu_clk_enable(cpu_clk_enable[0]), .busy(busy[0]), .done(done[0]),
    .status(status[0]), .cycle_count(cycle_count[0]), .result_v0(result_v0[0]));

  mips_cpu_run_controller #(.TIMEOUT_CYCLES(100)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .cpu_active(cpu_active[1]),
    .cpu_register_v0(cpu_register_v0[1]), .cpu_reset(cpu_reset[1]),
    .cpu_clk_enable(cpu_clk_enable[1]), .busy(busy[1]), .done(done[1]),
    .status(status[1]), .cycle_count(cycle_count[1]), .result_v0(result_v0[1]));

  mips_cpu_run_controller #(.STALL_PERIOD(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .cpu_active(cpu_active[2]),
    .cpu_register_v0(cpu_register_v0[2]), .cpu_reset(cpu_reset[2]),
    .cpu_clk_enable(cpu_clk_enable[2]), .busy(busy[2]), .done(done[2]),
    .status(status[2]), .cycle_count(cycle_count[2]), .result_v0(result_v0[2]));

  mips_cpu_run_controller #(.TIMEOUT_CYCLES(20), .STALL_PERIOD(1)) u_dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .cpu_active(cpu_active[3]),
    .cpu_register_v0(cpu_register_v0[3]), .cpu_reset(cpu_reset[3]),
    .cpu_clk_enable(cpu_clk_enable[3]), .busy(busy[3]), .done(done[3]),
    .status(status[3]), .cycle_count(cycle_count[3]), .result_v0(result_v0[3]));

  always #5 clk = ~clk;

  function automatic int stall_of(input int i);
    case (i)
      2:       return 4;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_enable(input int i, input int r);
    int p;
    p = stall_of(i);
    if (p >= 2) return (r % p) != (p - 1);
    return 1'b1;
  endfunction

  // Behavioural CPU: goes active act_delay cycles after its reset ends, then
  // drops cpu_active (presenting halt_v0) on its halt_after-th enabled cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      cpu_register_v0[i] = 32'hDEAD_BEEF;
      if (reset) begin
        cpu_active[i] = 1'b0;
        phase[i] = 0; since[i] = 0; en_count[i] = 0; run_cycles[i] = 0;
        stalls[i] = 0; bad_en[i] = 0; rst_w[i] = 0; done_lat[i] = 0;
        done_seen[i] = 1'b0; prev_rst[i] = 1'b0;
      end else begin
        if (cpu_reset[i]) begin
          if (!prev_rst[i]) begin
            rst_rises[i]++;
            rst_w[i] = 0;
          end
          rst_w[i]++;
          cpu_active[i] = 1'b0;
          phase[i] = 0; since[i] = 0; en_count[i] = 0; run_cycles[i] = 0;
          stalls[i] = 0; bad_en[i] = 0; done_lat[i] = 0; done_seen[i] = 1'b0;
        end else if (busy[i]) begin
          case (phase[i])
            0: if (!never_active[i] && since[i] == act_delay[i]) begin
                 cpu_active[i] = 1'b1;
                 phase[i] = 1;
               end
            1: begin
                 if (cpu_clk_enable[i] !== exp_enable(i, run_cycles[i])) bad_en[i]++;
                 run_cycles[i]++;
                 if (cpu_clk_enable[i]) en_count[i]++;
                 else stalls[i]++;
                 if (halt_after[i] != 0 && cpu_clk_enable[i] &&
                     en_count[i] == halt_after[i]) begin
                   cpu_active[i]      = 1'b0;
                   cpu_register_v0[i] = halt_v0[i];
                   phase[i]           = 2;
                 end
               end
            default: ;
          endcase
          since[i]++;
        end
        if (done[i] && !done_seen[i]) begin
          done_seen[i] = 1'b1;
          done_lat[i]  = since[i];
        end
        prev_rst[i] = cpu_reset[i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int k;
    k = 0;
    while (!done[i] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done"}, 32'(done[i]), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input int i, input string tag);
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset[i]), 32'd0);
    check_eq({tag, "_clk_en"},    32'(cpu_clk_enable[i]), 32'd0);
    check_eq({tag, "_busy"},      32'(busy[i]), 32'd0);
    check_eq({tag, "_done_flag"}, 32'(done[i]), 32'd0);
    check_eq({tag, "_status"},    32'(status[i]), 32'd0);
    check_eq({tag, "_count"},     cycle_count[i], 32'd0);
    check_eq({tag, "_v0"},        result_v0[i], 32'd0);
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; act_delay[i] = 0; halt_after[i] = 0;
      never_active[i] = 1'b0; halt_v0[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_values(0, "por");
    reset = 1'b0;

    // Default parameters: halt after 50 enabled cycles with v0 = 0x2A
    act_delay[0] = 1; halt_after[0] = 50; halt_v0[0] = 32'h0000_002A;
    r0 = rst_rises[0];
    pulse_start(0);
    check_eq("halt_rst_high",  32'(cpu_reset[0]), 32'd1);
    check_eq("halt_busy",      32'(busy[0]), 32'd1);
    check_eq("halt_rst_clken", 32'(cpu_clk_enable[0]), 32'd1);
    wait_done(0, 200, "halt");
    check_eq("halt_status", 32'(status[0]), 32'h1);
    check_eq("halt_v0",     result_v0[0], 32'h2A);
    check_eq("halt_count",  cycle_count[0], 32'd50);
    check_eq("halt_clken",  32'(cpu_clk_enable[0]), 32'd0);
    check_eq("halt_busy_lo", 32'(busy[0]), 32'd0);
    check_eq("halt_rst_w",  32'(rst_w[0]), 32'd2);
    check_eq("halt_rises",  32'(rst_rises[0] - r0), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("hold_count",  cycle_count[0], 32'd50);
    check_eq("hold_status", 32'(status[0]), 32'h1);
    check_eq("hold_v0",     result_v0[0], 32'h2A);

    // Never-active CPU, restarted from DONE
    never_active[0] = 1'b1;
    pulse_start(0);
    check_eq("noact_cleared_status", 32'(status[0]), 32'h0);
    wait_done(0, 50, "noact");
    check_eq("noact_status", 32'(status[0]), 32'h3);
    check_eq("noact_lat",    32'(done_lat[0]), 32'd4);
    check_eq("noact_count",  cycle_count[0], 32'd0);
    check_eq("noact_v0",     result_v0[0], 32'd0);
    check_eq("noact_clken",  32'(cpu_clk_enable[0]), 32'd0);
    never_active[0] = 1'b0;

    // TIMEOUT_CYCLES=100, cpu_active stuck high, extra start mid-run ignored
    act_delay[1] = 0; halt_after[1] = 0;
    r0 = rst_rises[1];
    pulse_start(1);
    repeat (30) @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, 300, "tmo");
    check_eq("tmo_status", 32'(status[1]), 32'h2);
    check_eq("tmo_count",  cycle_count[1], 32'd100);
    check_eq("tmo_v0",     result_v0[1], 32'd0);
    check_eq("tmo_rises",  32'(rst_rises[1] - r0), 32'd1);

    // STALL_PERIOD=4: 30 enabled cycles span 39 RUN cycles with 9 stalls
    act_delay[2] = 2; halt_after[2] = 30; halt_v0[2] = 32'h0000_1234;
    pulse_start(2);
    wait_done(2, 200, "stall");
    check_eq("stall_status",  32'(status[2]), 32'h1);
    check_eq("stall_count",   cycle_count[2], 32'd30);
    check_eq("stall_v0",      result_v0[2], 32'h1234);
    check_eq("stall_n",       32'(stalls[2]), 32'd9);
    check_eq("stall_pattern", 32'(bad_en[2]), 32'd0);

    // TIMEOUT_CYCLES=20, STALL_PERIOD=1: halt on the 20th cycle beats timeout
    act_delay[3] = 0; halt_after[3] = 20; halt_v0[3] = 32'h0000_0055;
    pulse_start(3);
    wait_done(3, 200, "tie");
    check_eq("tie_status",  32'(status[3]), 32'h1);
    check_eq("tie_count",   cycle_count[3], 32'd20);
    check_eq("tie_v0",      result_v0[3], 32'h55);
    check_eq("tie_nostall", 32'(stalls[3]), 32'd0);

    // Reset mid-RUN with start also high, then a fresh run
    act_delay[0] = 0; halt_after[0] = 0;
    pulse_start(0);
    repeat (15) @(negedge clk);
    check_eq("mid_busy",  32'(busy[0]), 32'd1);
    check_eq("mid_count", cycle_count[0], 32'd12);
    reset = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check_reset_values(0, "midrst");
    reset = 1'b0;
    start[0] = 1'b0;
    halt_after[0] = 7; halt_v0[0] = 32'h0000_0077;
    @(negedge clk);
    r0 = rst_rises[0];
    pulse_start(0);
    wait_done(0, 200, "fresh");
    check_eq("fresh_status", 32'(status[0]), 32'h1);
    check_eq("fresh_count",  cycle_count[0], 32'd7);
    check_eq("fresh_v0",     result_v0[0], 32'h77);
    check_eq("fresh_rst_w",  32'(rst_w[0]), 32'd2);
    check_eq("fresh_rises",  32'(rst_rises[0] - r0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_run_controller.md
MIPS_CPU_RUN_CONTROLLER -- requirements
Module: mips_cpu_run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: cycles cpu_reset is held high per run (min 1).
REQ-002 SHALL have parameter ACTIVE_WAIT, default 4: cycles allowed after cpu_reset falls for cpu_active to rise.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000: max enabled CPU cycles per run.
REQ-004 SHALL have parameter STALL_PERIOD, default 0: 0 = no stalls; N>=2 = cpu_clk_enable low one cycle in every N during RUN.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port start, input, 1: begin a run when sampled high in IDLE or DONE.
REQ-008 SHALL have port cpu_active, input, 1: CPU running flag.
REQ-009 SHALL have port cpu_register_v0, input, 32: CPU $v0.
REQ-010 SHALL have port cpu_reset, output, 1: reset driven to the CPU.
REQ-011 SHALL have port cpu_clk_enable, output, 1: clock enable driven to the CPU.
REQ-012 SHALL have port busy, output, 1: high in RST, WAIT and RUN.
REQ-013 SHALL have port done, output, 1: high in DONE.
REQ-014 SHALL have port status, output, 2: 00 none, 01 halted, 10 timeout, 11 never-active.
REQ-015 SHALL have port cycle_count, output, 32: enabled cycles spent in RUN.
REQ-016 SHALL have port result_v0, output, 32: cpu_register_v0 captured at halt.

Function
REQ-017 SHALL implement FSM states IDLE, RST, WAIT, RUN, DONE; all outputs registered.
REQ-018 IDLE/DONE + start -> RST; status, cycle_count and result_v0 cleared on entry to RST.
REQ-019 RST: cpu_reset=1, cpu_clk_enable=1 for exactly RESET_CYCLES cycles, then -> WAIT.
REQ-020 WAIT: cpu_reset=0, cpu_clk_enable=1; cpu_active=1 -> RUN; ACTIVE_WAIT cycles without it -> DONE, status=11.
REQ-021 RUN: cycle_count increments on each cycle with cpu_clk_enable=1; saturates at 2^32-1.
REQ-022 RUN: cpu_active sampled 0 -> DONE next cycle, status=01, result_v0 = cpu_register_v0 sampled that same cycle.
REQ-023 RUN: cycle_count reaching TIMEOUT_CYCLES -> DONE next cycle, status=10, result_v0=0.
REQ-024 Halt and timeout detected in the same cycle SHALL resolve as halt (status=01).
REQ-025 Stall generator: mod-STALL_PERIOD counter cleared on RUN entry; cpu_clk_enable=0 when counter = STALL_PERIOD-1, else 1; stalled cycles not counted.
REQ-026 STALL_PERIOD of 1 SHALL be treated as 0.
REQ-027 cpu_clk_enable SHALL be 0 in IDLE and DONE (CPU frozen); cpu_reset SHALL be 0 outside RST.
REQ-028 start SHALL be ignored in RST, WAIT and RUN.
REQ-029 DONE SHALL hold status, cycle_count and result_v0 stable until start or reset.

Reset
REQ-030 reset SHALL force IDLE within one cycle from any state, including mid-run.
REQ-031 Reset values: cpu_reset=0, cpu_clk_enable=0, busy=0, done=0, status=00, cycle_count=0, result_v0=0.
REQ-032 reset SHALL take priority over start when both are high.

Structure
REQ-033 Package mips_cpu_run_pkg SHALL hold the state enum and the status-code constants.
REQ-034 The stall counter SHALL be sub-module mips_cpu_run_stall_gen (inputs clk, reset, enable; output clk_enable).

Verification
REQ-035 Defaults, start pulse, CPU model drops cpu_active after 50 enabled cycles with v0=0x0000002A -> status=01, result_v0=0x2A, cycle_count=50, cpu_clk_enable=0.
REQ-036 TIMEOUT_CYCLES=100, cpu_active stuck high -> status=10, cycle_count=100, done high.
REQ-037 cpu_active never rises -> DONE exactly 4 cycles after cpu_reset falls, status=11.
REQ-038 STALL_PERIOD=4, halt after 30 enabled cycles -> cpu_clk_enable low every 4th RUN cycle, cycle_count=30.
REQ-039 reset asserted mid-RUN, then start -> IDLE and reset values, then a fresh RESET_CYCLES-long cpu_reset pulse and counts from 0.
REQ-040 TIMEOUT_CYCLES=20, cpu_active falls on the 20th enabled cycle -> status=01, not 10.
